// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared constants, state encodings and request type for the imem arbiter
// Purpose: common definitions imported by imem_access_arbiter and its testbench.
// Contents: IMEM_ADDR_W / IMEM_DATA_W, FSM state constants, request struct, alignment helper.
package imem_arb_pkg;

    localparam int IMEM_ADDR_W = 11;
    localparam int IMEM_DATA_W = 32;

    // Arbiter FSM states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // One requester's view of a memory access (fetch drives we=0, wdata=0)
    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [IMEM_ADDR_W-1:0] addr;
        logic [IMEM_DATA_W-1:0] wdata;
    } imem_req_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/imem_arb_burst_ctr.sv
// rtl/imem_arb_burst_ctr.sv - saturating fetch-burst counter and debug override decision
// Purpose: counts consecutive fetch grants while debug waits; forces a debug win at the limit.
// Ports:
//   i_clk, i_reset (async active-low)
//   i_d_req       debug request pending
//   i_f_gnt       fetch granted this cycle
//   i_d_gnt       debug granted this cycle
//   o_d_override  debug must win this cycle
module imem_arb_burst_ctr #(
    parameter int MAX_FETCH_BURST = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d_req,
    input  logic i_f_gnt,
    input  logic i_d_gnt,
    output logic o_d_override
);

    localparam int               CNT_W   = $clog2(MAX_FETCH_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FETCH_BURST);

    logic [CNT_W-1:0] r_cnt;

    // Starvation only accumulates while debug is actually waiting
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_d_gnt || !i_d_req) begin
            r_cnt <= '0;
        end else if (i_f_gnt && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Depends only on the register and the request, so no loop through the grant logic
    assign o_d_override = i_d_req && (r_cnt == CNT_MAX);

endmodule

// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - fetch/debug arbiter for the single-port instruction memory
// Purpose: shares one 2 KiB instruction memory between core fetch (read) and debug/loader
//   (read/write), registers read data into a one-cycle response, bounds fetch starvation
//   of debug, and provides a halt mode giving debug exclusive access.
// Ports:
//   i_clk, i_reset (async active-low)
//   fetch:  i_f_req, i_f_addr -> o_f_gnt, o_f_rvalid, o_f_rdata
//   debug:  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_halt
//           -> o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err, o_halted
//   memory: o_mem_addr, o_mem_we, o_mem_wdata, i_mem_rdata (combinational read)
// Optional: define IMEM_ARB_PERF_EN to add o_perf_fetch_cnt, o_perf_debug_cnt, o_perf_stall_cnt.
module imem_access_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W          = IMEM_ADDR_W,
    parameter int DATA_W          = IMEM_DATA_W,
    parameter int MAX_FETCH_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic              i_d_halt,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_err,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef IMEM_ARB_PERF_EN
   ,output logic [31:0]       o_perf_fetch_cnt,
    output logic [31:0]       o_perf_debug_cnt,
    output logic [31:0]       o_perf_stall_cnt
`endif
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_d_override;
    logic              w_f_gnt;
    logic              w_d_gnt;
    logic              w_d_mis;
    logic              r_f_rvalid;
    logic [DATA_W-1:0] r_f_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    // ------------------------------------------------------------------
    // FSM: the cycle in which halt rises is still arbitrated under RUN;
    // DRAIN then spends one cycle letting a fetch response complete.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (i_d_halt) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = i_d_halt ? ST_HALT : ST_RUN;
            ST_HALT:  if (!i_d_halt) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration. Grants are gated by i_reset directly so they drop the
    // instant reset asserts, not at the next edge.
    // ------------------------------------------------------------------
    imem_arb_burst_ctr #(
        .MAX_FETCH_BURST (MAX_FETCH_BURST)
    ) u_burst_ctr (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_d_req      (i_d_req),
        .i_f_gnt      (w_f_gnt),
        .i_d_gnt      (w_d_gnt),
        .o_d_override (w_d_override)
    );

    assign w_d_mis = is_misaligned(i_d_addr[1:0]);
    assign w_f_gnt = i_reset && (r_state == ST_RUN) && i_f_req && !w_d_override;
    assign w_d_gnt = i_reset && i_d_req && !w_f_gnt;

    assign o_f_gnt  = w_f_gnt;
    assign o_d_gnt  = w_d_gnt;
    assign o_halted = (r_state == ST_HALT);

    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (w_d_gnt) begin
            o_mem_addr  = i_d_addr;
            o_mem_we    = i_d_we && !w_d_mis;
            o_mem_wdata = i_d_wdata;
        end else if (w_f_gnt) begin
            o_mem_addr  = i_f_addr;
        end
    end

    // ------------------------------------------------------------------
    // Responses: one-cycle registered read data. Debug writes and
    // misaligned accesses return zero data.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            r_f_rvalid <= w_f_gnt;
            r_d_rvalid <= w_d_gnt;
            r_d_err    <= w_d_gnt && w_d_mis;
            if (w_f_gnt) begin
                r_f_rdata <= i_mem_rdata;
            end
            if (w_d_gnt) begin
                r_d_rdata <= (i_d_we || w_d_mis) ? '0 : i_mem_rdata;
            end
        end
    end

    assign o_f_rvalid = r_f_rvalid;
    assign o_f_rdata  = r_f_rdata;
    assign o_d_rvalid = r_d_rvalid;
    assign o_d_rdata  = r_d_rdata;
    assign o_d_err    = r_d_err;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_debug;
    logic [31:0] r_perf_stall;

    // A stall cycle is any cycle where at least one port waits
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_perf_fetch <= '0;
            r_perf_debug <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_f_gnt) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_d_gnt) r_perf_debug <= r_perf_debug + 32'd1;
            if ((i_f_req && !w_f_gnt) || (i_d_req && !w_d_gnt)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch;
    assign o_perf_debug_cnt = r_perf_debug;
    assign o_perf_stall_cnt = r_perf_stall;
`else
    // Performance counters not built
`endif

endmodule
